accel_sequencer: RTL
====================

ACCEL_SEQUENCER -- requirements
Module: accel_sequencer

Interface
REQ-001 Parameter: WAKE_CYCLES, 4, cycles waited after each state entry before phase_req (bank power settling).
REQ-002 Parameter: TIMEOUT_CYCLES, 65535, maximum cycles phase_req may stay high without phase_ack.
REQ-003 Parameter: CNT_W, 16, width of the wake and timeout counters.
REQ-004 The interface is fixed as decided: one clock; reset is synchronous and active-high.
REQ-005 Port: clk, input, 1, sole clock, rising edge.
REQ-006 Port: rst, input, 1, synchronous active-high reset.
REQ-007 Port: start, input, 1, request a transaction; sampled only in STATE_IDLE.
REQ-008 Port: accel_sel, input, accel_type_e, accelerator for the transaction; sampled with start.
REQ-009 Port: skip_weights, input, 1, weights already resident; sampled with start.
REQ-010 Port: abort, input, 1, cancel the current transaction.
REQ-011 Port: phase_ack, input, 1, phase-complete handshake from the datapath.
REQ-012 Port: phase_req, output, 1, request the datapath to execute the current phase.
REQ-013 Port: current_state, output, state_e, FSM state driven to power_manager.
REQ-014 Port: active_accel, output, accel_type_e, latched accelerator driven to power_manager.
REQ-015 Port: accel_active, output, 1, transaction in progress, driven to power_manager.
REQ-016 Port: busy, output, 1, high when current_state != STATE_IDLE.
REQ-017 Port: done, output, 1, single-cycle completion pulse.
REQ-018 Port: error, output, 1, sticky timeout flag.

Function
REQ-019 All outputs are registered; no combinational input-to-output path.
REQ-020 Sequence: IDLE -> LOAD_WEIGHTS -> LOAD_INPUT -> COMPUTE -> STORE_OUTPUT -> DONE -> IDLE; LOAD_WEIGHTS is bypassed (IDLE -> LOAD_INPUT) when skip_weights=1 at start.
REQ-021 Start acceptance: in IDLE with start=1 and abort=0, the next cycle shows the first work state, with active_accel=accel_sel, accel_active=1, and error=0.
REQ-022 start is ignored outside IDLE; accel_sel and skip_weights are ignored outside the start cycle.
REQ-023 Entry cycle: the first cycle current_state shows a work state is cycle 0; the wake counter loads WAKE_CYCLES at entry.
REQ-024 phase_req first rises on cycle WAKE_CYCLES after entry; with WAKE_CYCLES=0 it is high on the entry cycle.
REQ-025 Ack handling: phase_ack=1 while phase_req=1 completes the phase, so the next cycle has phase_req=0 and the next state.
REQ-026 phase_ack while phase_req=0 is ignored.
REQ-027 DONE lasts exactly one cycle; done=1 only in that cycle; next state is IDLE.
REQ-028 accel_active=1 in every non-IDLE state, including DONE, and 0 in IDLE.
REQ-029 active_accel holds its last latched value in IDLE.
REQ-030 Timeout counter: clears at each state entry and increments each cycle phase_req=1 and phase_ack=0.
REQ-031 On the cycle the timeout counter reaches TIMEOUT_CYCLES, the next cycle has error=1, current_state=IDLE, phase_req=0, accel_active=0, and no done pulse.
REQ-032 error stays high until the next accepted start.
REQ-033 Abort: abort=1 in any non-IDLE state gives, next cycle, IDLE, phase_req=0, accel_active=0, error unchanged, and no done.
REQ-034 abort has priority over phase_ack and over timeout in the same cycle.
REQ-035 abort=1 in IDLE blocks start that cycle.
REQ-036 Counters saturate and never wrap.

Reset
REQ-037 rst=1 at any clock edge, including mid-transaction, forces the following on the next cycle: current_state=STATE_IDLE, active_accel=ACCEL_MLP, accel_active=0, phase_req=0, busy=0, done=0, error=0, and both counters=0.

Verification
REQ-038 MLP full run:
- Stimulus: WAKE_CYCLES=4, skip_weights=0; phase_ack asserted 1 cycle after each phase_req rise.
- Response: each work state lasts 6 cycles; states LW, LI, COMPUTE, SO, then DONE for 1 cycle with done=1, then IDLE.
REQ-039 CNN skip-weights run:
- Stimulus: skip_weights=1; accel_sel changed to RNN mid-run.
- Response: LOAD_WEIGHTS never appears; active_accel=CNN throughout.
REQ-040 Timeout:
- Stimulus: TIMEOUT_CYCLES=16; phase_ack withheld in COMPUTE.
- Response: after 16 cycles of phase_req high, error=1, IDLE, done never pulses.
- Follow-up: next start clears error.
REQ-041 Abort collision:
- Stimulus: abort and phase_ack high together in LOAD_INPUT.
- Response: next cycle IDLE, accel_active=0, error=0, no done.
REQ-042 Busy and reset:
- Stimulus: start pulsed while in COMPUTE.
- Response: start ignored.
- Stimulus: rst asserted mid-COMPUTE.
- Response: all outputs at REQ-037 values next cycle.

Source files
------------

// File: rtl/accel_sequencer.sv
// accel_sequencer: per-transaction phase sequencer for the accelerator datapath.
// Walks LOAD_WEIGHTS (optional) -> LOAD_INPUT -> COMPUTE -> STORE_OUTPUT -> DONE,
// waiting WAKE_CYCLES after each work-state entry for bank power to settle
// before requesting the phase. All outputs come straight from flops.
//
// Handshake: phase_req is held high until the datapath returns phase_ack;
// a cycle with phase_req=1 and phase_ack=1 completes the phase and the FSM
// moves on next cycle. phase_ack while phase_req=0 carries no meaning.

package accel_sequencer_pkg;
   typedef enum logic [1:0] {
      ACCEL_MLP = 2'd0,
      ACCEL_CNN = 2'd1,
      ACCEL_RNN = 2'd2
   } accel_type_e;

   typedef enum logic [2:0] {
      STATE_IDLE         = 3'd0,
      STATE_LOAD_WEIGHTS = 3'd1,
      STATE_LOAD_INPUT   = 3'd2,
      STATE_COMPUTE      = 3'd3,
      STATE_STORE_OUTPUT = 3'd4,
      STATE_DONE         = 3'd5
   } state_e;
endpackage

module accel_sequencer
   import accel_sequencer_pkg::*;
#(
   parameter int WAKE_CYCLES    = 4,
   parameter int TIMEOUT_CYCLES = 65535,
   parameter int CNT_W          = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  accel_type_e accel_sel,
   input  logic        skip_weights,
   input  logic        abort,
   input  logic        phase_ack,
   output logic        phase_req,
   output state_e      current_state,
   output accel_type_e active_accel,
   output logic        accel_active,
   output logic        busy,
   output logic        done,
   output logic        error
);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  wake_q, wake_d;
   logic [CNT_W-1:0]  to_q, to_d;
   logic              phase_req_q, phase_req_d;
   logic              error_q, error_d;
   accel_type_e       accel_q, accel_d;
   logic              enter_work;
   logic [CNT_W:0]    to_inc;
   logic              timeout_hit;

   // The current unacknowledged cycle is the TIMEOUT_CYCLES-th with phase_req high.
   assign to_inc      = {1'b0, to_q} + {{CNT_W{1'b0}}, 1'b1};
   assign timeout_hit = (to_inc >= (CNT_W+1)'(TIMEOUT_CYCLES));

   // Successor of each work state; STORE_OUTPUT hands over to DONE.
   function automatic state_e next_work(input state_e s);
      case (s)
         STATE_LOAD_WEIGHTS: next_work = STATE_LOAD_INPUT;
         STATE_LOAD_INPUT:   next_work = STATE_COMPUTE;
         STATE_COMPUTE:      next_work = STATE_STORE_OUTPUT;
         STATE_STORE_OUTPUT: next_work = STATE_DONE;
         default:            next_work = STATE_IDLE;
      endcase
   endfunction

   // Next-state, counter and registered-output logic.
   always_comb begin
      state_d     = state_q;
      wake_d      = (wake_q != '0) ? wake_q - CNT_W'(1) : '0;
      to_d        = to_q;
      phase_req_d = phase_req_q;
      error_d     = error_q;
      accel_d     = accel_q;
      enter_work  = 1'b0;

      case (state_q)
         STATE_IDLE: begin
            phase_req_d = 1'b0;
            wake_d      = '0;
            to_d        = '0;
            if (start && !abort) begin
               accel_d    = accel_sel;
               error_d    = 1'b0;
               state_d    = skip_weights ? STATE_LOAD_INPUT : STATE_LOAD_WEIGHTS;
               enter_work = 1'b1;
            end
         end
         STATE_DONE: begin
            state_d     = STATE_IDLE;
            phase_req_d = 1'b0;
            wake_d      = '0;
            to_d        = '0;
         end
         default: begin
            // abort outranks both a completing ack and a timeout
            if (abort) begin
               state_d     = STATE_IDLE;
               phase_req_d = 1'b0;
               wake_d      = '0;
               to_d        = '0;
            end else if (phase_req_q && phase_ack) begin
               state_d = next_work(state_q);
               if (state_d == STATE_DONE) begin
                  phase_req_d = 1'b0;
                  wake_d      = '0;
                  to_d        = '0;
               end else begin
                  enter_work = 1'b1;
               end
            end else if (phase_req_q) begin
               if (timeout_hit) begin
                  state_d     = STATE_IDLE;
                  error_d     = 1'b1;
                  phase_req_d = 1'b0;
                  wake_d      = '0;
                  to_d        = '0;
               end else if (to_q != '1) begin
                  to_d = to_q + CNT_W'(1);
               end
            end else begin
               // raise phase_req once the wake count has run down
               phase_req_d = (wake_q <= CNT_W'(1));
            end
         end
      endcase

      if (enter_work) begin
         wake_d      = CNT_W'(WAKE_CYCLES);
         to_d        = '0;
         phase_req_d = (WAKE_CYCLES == 0);
      end
   end

   // State and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= STATE_IDLE;
         wake_q      <= '0;
         to_q        <= '0;
         phase_req_q <= 1'b0;
         error_q     <= 1'b0;
         accel_q     <= ACCEL_MLP;
      end else begin
         state_q     <= state_d;
         wake_q      <= wake_d;
         to_q        <= to_d;
         phase_req_q <= phase_req_d;
         error_q     <= error_d;
         accel_q     <= accel_d;
      end
   end

   assign current_state = state_q;
   assign phase_req     = phase_req_q;
   assign active_accel  = accel_q;
   assign accel_active  = (state_q != STATE_IDLE);
   assign busy          = (state_q != STATE_IDLE);
   assign done          = (state_q == STATE_DONE);
   assign error         = error_q;

endmodule
